uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, idle-high line.
- Receiving end of the UART_tx link. Used inside the Segway DUT to accept BLE commands (e.g. 'g' = 0x67, 's' = 0x73) on RX.
- Also used in benches to capture what the DUT transmits.
- Synchronizes the line, samples each bit at mid-bit, and presents each byte through a rdy/clr_rdy handshake with framing and overrun flags.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200 baud). Legal range is >= 8; the bench may override it.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- RX  input  1  serial line, asynchronous to clk, idle high
- clr_rdy  input  1  consumer acknowledge; clears rdy, frm_err, ovr_err
- rx_data  output  8  last accepted byte
- rdy  output  1  high while an unacknowledged byte is held in rx_data
- frm_err  output  1  sticky; a stop bit was sampled low
- ovr_err  output  1  sticky; a byte completed while rdy was high
- par_err  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset acts immediately at any point, including mid-frame.
- Reset values: rx_data = 0x00; rdy, frm_err, ovr_err, par_err = 0. Both synchronizer flops = 1. State = IDLE. Baud counter = 0, bit counter = 0, shift register = 0.
- Synchronizer: RX passes through a 2-flop synchronizer. All logic uses the synchronized line rx_s. A falling edge is rx_s = 0 while its previous value = 1.
- States:
  - IDLE: on a falling edge, load the baud counter with BAUD_DIV/2 and go to START.
  - START: when the counter expires (half-bit point), sample rx_s. If 1, this is a false start: go to IDLE with no flags changed. If 0, load BAUD_DIV, clear the bit counter, go to DATA.
  - DATA: at each expiry, shift rx_s into the MSB of the shift register (LSB arrives first) and reload BAUD_DIV. After the 8th sample, go to STOP, or to PARITY when the feature is enabled.
  - STOP: at expiry, sample the stop bit, then go to IDLE in the same cycle. Returning at mid-stop-bit allows back-to-back frames with zero idle time.
- Stop sample = 1 (good frame):
  - If rdy = 0, or clr_rdy = 1 in the same cycle: rx_data <= shift register and rdy <= 1 on the next edge. Acceptance beats clear.
  - Otherwise: the byte is dropped, rx_data keeps the old byte, ovr_err <= 1.
- Stop sample = 0: frm_err <= 1, byte discarded, rdy and rx_data unchanged.
- clr_rdy alone: rdy, frm_err, ovr_err, par_err <= 0 on the next edge.
- rdy does not clear on a new start bit; only clr_rdy clears it.
- Latency: pin falling edge to rdy rising = 2 sync cycles + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles. At default this is 24741 cycles.
- RX held low continuously: one frame with frm_err = 1. After that, no new start is detected until rx_s returns to 1.
- Counter widths: the baud counter is sized $clog2(BAUD_DIV+1). The bit counter is 4 bits and cannot wrap within a frame.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: the frame carries an even-parity bit between D7 and the stop bit, handled by an added PARITY state sampled at mid-bit.
  - If the XOR of the 8 data bits and the parity bit = 1, par_err <= 1 and the byte is discarded.
  - Framing is still checked on the stop bit.
  - Latency grows by BAUD_DIV.
- Undefined: no PARITY state; par_err is tied 0.

Test Plan:
- Reset, then send 0x67 at default BAUD_DIV -> rdy rises exactly 24741 cycles after the RX falling edge; rx_data = 0x67; frm_err = ovr_err = 0.
- Send 0x67 then 0x73 back-to-back with zero idle; pulse clr_rdy after the first rdy -> the second byte is accepted, rx_data = 0x73, ovr_err = 0.
- Drive RX low for 500 cycles then high -> false start; rdy stays 0, no flags; a following 0xA5 is received correctly.
- Send 0x55 with the stop bit forced low -> frm_err = 1, rdy = 0, rx_data unchanged. Then clr_rdy -> frm_err = 0.
- Send 0x11, then 0x22 without clr_rdy -> rx_data = 0x11, ovr_err = 1. Repeat with clr_rdy asserted on the 0x22 stop-sample cycle -> rx_data = 0x22, rdy = 1, ovr_err = 0.
- Assert rst_n low during D3 of 0xF0 -> all outputs return to reset values immediately; the next 0x3C is received correctly. Under UART_PARITY_EN, 0x3C with a wrong parity bit -> par_err = 1, rdy = 0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, rdy/clr_rdy handshake with sticky error flags.
// Optional feature macro UART_PARITY_EN adds an even-parity bit between D7 and the stop bit.
`timescale 1ns/1ps
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       par_err
);
    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rdy_q, rdy_d;
    logic             frm_q, frm_d;
    logic             ovr_q, ovr_d;
    logic             expire;
    logic             par_bad;
`ifdef UART_PARITY_EN
    logic             par_q, par_d;
    logic             bad_q, bad_d;
    assign par_bad = bad_q;
`else
    assign par_bad = 1'b0;
`endif

    // The counter is reloaded on expiry, so a load of N yields the action N cycles later.
    assign expire = (baud_cnt_q == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            frm_q      <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_PARITY_EN
            par_q      <= 1'b0;
            bad_q      <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= RX;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_q      <= frm_d;
            ovr_q      <= ovr_d;
`ifdef UART_PARITY_EN
            par_q      <= par_d;
            bad_q      <= bad_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_d      = frm_q;
        ovr_d      = ovr_q;
`ifdef UART_PARITY_EN
        par_d      = par_q;
        bad_d      = bad_q;
`endif
        if (clr_rdy) begin
            rdy_d = 1'b0;
            frm_d = 1'b0;
            ovr_d = 1'b0;
`ifdef UART_PARITY_EN
            par_d = 1'b0;
`endif
        end
        if (state_q != IDLE) begin
            baud_cnt_d = baud_cnt_q - CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q && rx_prev_q) begin
                    baud_cnt_d = CNT_HALF;
                    state_d    = START;
                end
            end
            START: begin
                if (expire) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        baud_cnt_d = CNT_FULL;
                        bit_cnt_d  = '0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    baud_cnt_d = CNT_FULL;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (expire) begin
                    baud_cnt_d = CNT_FULL;
                    bad_d      = ^shift_q ^ rx_s_q;
                    if (^shift_q ^ rx_s_q) begin
                        par_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught.
                if (expire) begin
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        frm_d = 1'b1;
                    end else if (!par_bad) begin
                        if (!rdy_q || clr_rdy) begin
                            rx_data_d = shift_q;
                            rdy_d     = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_q;
    assign ovr_err = ovr_q;
`ifdef UART_PARITY_EN
    assign par_err = par_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx; one default-rate instance for the
// latency/false-start checks and one fast-rate instance for the remaining frame scenarios.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BD_DEF = 2604;
    localparam int BD_SML = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAT_DEF = 2 + BD_DEF / 2 + (NBITS - 1) * BD_DEF + 1;

    logic       clk = 1'b0;
    logic       rst_n, rx_line, clr_rdy, sel_def;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       rdy_a, frm_a, ovr_a, par_a;
    logic       rdy_b, frm_b, ovr_b, par_b;
    logic [7:0] obs_data;
    logic       obs_rdy, obs_frm, obs_ovr, obs_par;

    int         n_vec, n_err;
    int         cyc = 0;
    int         t_fall = 0;
    int         t_rdy = 0;
    logic       rdy_seen = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign rx_a     = sel_def ? rx_line : 1'b1;
    assign rx_b     = sel_def ? 1'b1 : rx_line;
    assign obs_data = sel_def ? data_a : data_b;
    assign obs_rdy  = sel_def ? rdy_a : rdy_b;
    assign obs_frm  = sel_def ? frm_a : frm_b;
    assign obs_ovr  = sel_def ? ovr_a : ovr_b;
    assign obs_par  = sel_def ? par_a : par_b;

    uart_rx u_def (
        .clk(clk), .rst_n(rst_n), .RX(rx_a), .clr_rdy(clr_rdy),
        .rx_data(data_a), .rdy(rdy_a), .frm_err(frm_a), .ovr_err(ovr_a), .par_err(par_a)
    );

    uart_rx #(.BAUD_DIV(BD_SML)) u_sml (
        .clk(clk), .rst_n(rst_n), .RX(rx_b), .clr_rdy(clr_rdy),
        .rx_data(data_b), .rdy(rdy_b), .frm_err(frm_b), .ovr_err(ovr_b), .par_err(par_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (obs_rdy && !rdy_seen) t_rdy <= cyc;
        rdy_seen <= obs_rdy;
    end

    function automatic int cur_bd();
        return sel_def ? BD_DEF : BD_SML;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // clr_mode: 0 none, 1 pulse at start of frame, 2 pulse on the stop-sample cycle.
    task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip,
                        input int clr_mode, input logic expect_ok);
        int bd;
        bd = cur_bd();
        if (expect_ok) exp_q.push_back(b);
        rx_line = 1'b0;
        t_fall  = cyc;
        if (clr_mode == 1) begin
            clr_rdy = 1'b1;
            @(negedge clk);
            clr_rdy = 1'b0;
            repeat (bd - 1) @(negedge clk);
        end else begin
            repeat (bd) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (bd) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_line = (^b) ^ par_flip;
        repeat (bd) @(negedge clk);
`endif
        rx_line = stop_v;
        if (clr_mode == 2) begin
            repeat (2 + bd / 2) @(negedge clk);
            clr_rdy = 1'b1;
            @(negedge clk);
            clr_rdy = 1'b0;
            repeat (bd - 3 - bd / 2) @(negedge clk);
        end else begin
            repeat (bd) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic check_rx(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        while (!obs_rdy && n < 12 * cur_bd()) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, 32'(obs_rdy), 32'd1);
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check({tag, "_data"}, 32'(obs_data), 32'(e));
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; rx_line = 1'b1; clr_rdy = 1'b0; sel_def = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_def", 32'({data_a, rdy_a, frm_a, ovr_a, par_a}), 32'd0);
        check("reset_sml", 32'({data_b, rdy_b, frm_b, ovr_b, par_b}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send(8'h67, 1'b1, 1'b0, 0, 1'b1);
        check("lat_67", 32'(t_rdy - t_fall), 32'(LAT_DEF));
        check_rx("rx_67");
        check("err_67", 32'({obs_frm, obs_ovr, obs_par}), 32'd0);
        pulse_clr();
        check("clr_rdy", 32'(obs_rdy), 32'd0);

        rx_line = 1'b0;
        repeat (500) @(negedge clk);
        rx_line = 1'b1;
        repeat (2000) @(negedge clk);
        check("false_start", 32'({obs_rdy, obs_frm, obs_ovr, obs_par}), 32'd0);
        send(8'hA5, 1'b1, 1'b0, 0, 1'b1);
        check_rx("rx_a5");
        pulse_clr();

        sel_def = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h67, 1'b1, 1'b0, 0, 1'b1);
        check_rx("b2b_67");
        send(8'h73, 1'b1, 1'b0, 1, 1'b1);
        check_rx("b2b_73");
        check("b2b_ovr", 32'(obs_ovr), 32'd0);
        pulse_clr();

        send(8'h55, 1'b0, 1'b0, 0, 1'b0);
        repeat (BD_SML) @(negedge clk);
        check("frm_set", 32'({obs_rdy, obs_frm}), 32'b01);
        check("frm_data", 32'(obs_data), 32'h73);
        pulse_clr();
        check("frm_clr", 32'(obs_frm), 32'd0);

        send(8'h11, 1'b1, 1'b0, 0, 1'b1);
        send(8'h22, 1'b1, 1'b0, 0, 1'b0);
        repeat (BD_SML) @(negedge clk);
        check_rx("ovr_11");
        check("ovr_set", 32'(obs_ovr), 32'd1);
        pulse_clr();
        send(8'h11, 1'b1, 1'b0, 0, 1'b1);
        check_rx("acc_11");
        send(8'h22, 1'b1, 1'b0, 2, 1'b1);
        check_rx("acc_22");
        check("acc_flags", 32'({obs_rdy, obs_ovr}), 32'b10);

        // 0xF0 interrupted by reset in the middle of D3
        rx_line = 1'b0;
        repeat (BD_SML) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_line = 1'b0;
            repeat (BD_SML) @(negedge clk);
        end
        rx_line = 1'b0;
        repeat (BD_SML / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        rx_line = 1'b1;
        #1 check("rst_mid", 32'({obs_data, obs_rdy, obs_frm, obs_ovr, obs_par}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h3C, 1'b1, 1'b0, 0, 1'b1);
        check_rx("rst_3c");
        pulse_clr();

`ifdef UART_PARITY_EN
        send(8'h3C, 1'b1, 1'b1, 0, 1'b0);
        repeat (BD_SML) @(negedge clk);
        check("par_bad", 32'({obs_rdy, obs_frm, obs_par}), 32'b001);
        check("par_data", 32'(obs_data), 32'h3C);
        pulse_clr();
`endif

        rx_line = 1'b0;
        repeat (14 * BD_SML) @(negedge clk);
        check("low_frm", 32'({obs_rdy, obs_frm}), 32'b01);
        pulse_clr();
        repeat (14 * BD_SML) @(negedge clk);
        check("low_once", 32'({obs_rdy, obs_frm}), 32'b00);
        rx_line = 1'b1;
        repeat (4) @(negedge clk);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
